// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter sharing one FIFO write port
//
// Purpose:
//   Grants the write port of a single synchronous FIFO to one of NUM_REQ
//   producers at a time, for bursts of up to MAX_BURST words. Arbitration
//   is round-robin starting after the last grantee. The FIFO full flag is
//   used combinationally, so no write is ever issued into a full FIFO.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   per-requester "word available" flags
//   req_data   in   flattened data lanes, lane i = [i*DataWidth +: DataWidth]
//   fifo_full  in   FIFO full flag
//   ack        out  one-hot, high in the cycle a requester's word is written
//   grant      out  registered one-hot grant, zero when idle
//   grant_id   out  registered binary index of the grantee, zero when idle
//   busy       out  registered, high while a grant is held
//   burst_cnt  out  registered count of words written in the current grant
//   fifo_wr    out  FIFO write strobe
//   fifo_data  out  FIFO write data, lane of grant_id

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DataWidth = 16,
  parameter int MAX_BURST = 16,
  parameter int IdWidth   = 2,
  parameter int CntWidth  = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DataWidth-1:0]   req_data,
  input  logic                           fifo_full,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic [IdWidth-1:0]             grant_id,
  output logic                           busy,
  output logic [CntWidth-1:0]            burst_cnt,
  output logic                           fifo_wr,
  output logic [DataWidth-1:0]           fifo_data
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IdWidth-1:0]   grant_id_q, grant_id_d;
  logic [IdWidth-1:0]   last_q, last_d;
  logic                 busy_q, busy_d;
  logic [CntWidth-1:0]  burst_cnt_q, burst_cnt_d;

  // Round-robin search. Candidates above the last grantee take precedence
  // over those at or below it, which is the same as searching upward from
  // last+1 with wrap-around. Scanning downward lets the lowest index win.
  logic                 found_hi;
  logic [IdWidth-1:0]   win_hi;
  logic [IdWidth-1:0]   win_lo;
  logic [IdWidth-1:0]   winner;
  logic                 req_any;

  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (IdWidth'(j) > last_q)) begin
        found_hi = 1'b1;
        win_hi   = IdWidth'(j);
      end
      if (req[j] && (IdWidth'(j) <= last_q)) begin
        win_lo = IdWidth'(j);
      end
    end
    winner  = found_hi ? win_hi : win_lo;
    req_any = |req;
  end

  // Select the grantee's request bit and data lane. Comparing against each
  // index keeps the select in range when NUM_REQ is not a power of two.
  logic                 req_sel;
  logic [DataWidth-1:0] lane_data;

  always_comb begin
    req_sel   = 1'b0;
    lane_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IdWidth'(j) == grant_id_q) begin
        req_sel   = req[j];
        lane_data = req_data[j*DataWidth +: DataWidth];
      end
    end
  end

  // A write happens only while granted, the grantee still has a word and
  // the FIFO has room. Reset suppresses it so an abandoned burst never
  // leaves a stray word behind.
  logic accept;

  always_comb begin
    accept = (state_q == ST_GRANT) & req_sel & ~fifo_full & ~rst;
  end

  // Burst counter compare is done one bit wider so MAX_BURST equal to the
  // counter's full range still compares correctly.
  logic [CntWidth:0] cnt_inc;
  logic              burst_last;

  always_comb begin
    cnt_inc    = {1'b0, burst_cnt_q} + (CntWidth + 1)'(1);
    burst_last = (cnt_inc == (CntWidth + 1)'(MAX_BURST));
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d     = ST_GRANT;
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          grant_id_d  = winner;
          last_d      = winner;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // Release when the grantee drops its request, or when the word just
        // written completes a full burst. A full FIFO with the request held
        // simply waits here with the count frozen.
        if (!req_sel || (accept && burst_last)) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          grant_id_d  = '0;
          burst_cnt_d = '0;
        end else if (accept) begin
          burst_cnt_d = cnt_inc[CntWidth-1:0];
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        grant_id_d  = '0;
        burst_cnt_d = '0;
      end
    endcase

    busy_d = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      last_q      <= IdWidth'(NUM_REQ - 1);
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;
  assign fifo_wr   = accept;
  assign ack       = accept ? grant_q : '0;
  assign fifo_data = lane_data;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 16-bit, 2048-deep synchronous FIFO among NUM_REQ producers.
- Grants the FIFO write port to one requester at a time, for bursts of up to MAX_BURST words.
- Drives the FIFO's wr/data_in pins and honours its full flag.
- Sits between the producer blocks and the FIFO instance in the capture datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DataWidth, 16, word width; matches the FIFO data width.
- MAX_BURST, 16, maximum words accepted per grant before forced release (>=1).
- IdWidth, 2, width of the grant index; must equal clog2(NUM_REQ).
- CntWidth, 5, width of burst_cnt; must equal clog2(MAX_BURST+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; bit i held high while requester i has a word on its data lane.
- req_data  in  NUM_REQ*DataWidth  flattened data lanes; lane i is bits [i*DataWidth +: DataWidth].
- fifo_full  in  1  full flag from the FIFO.
- ack  out  NUM_REQ  bit i high in the cycle requester i's word is written; the requester advances to its next word on ack.
- grant  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- grant_id  out  IdWidth  binary index of the current grantee; 0 when idle.
- busy  out  1  registered; high while in GRANT state.
- burst_cnt  out  CntWidth  words accepted in the current grant.
- fifo_wr  out  1  write strobe to the FIFO.
- fifo_data  out  DataWidth  data to the FIFO; the lane of grant_id.

Behaviour:
- Reset (rst=1 at clock edge):
  - grant=0, grant_id=0, busy=0, burst_cnt=0, state=IDLE.
  - Priority pointer last=NUM_REQ-1, so requester 0 wins first.
  - ack and fifo_wr are 0 during reset.
  - Reset mid-burst abandons the burst immediately; no write occurs in the reset cycle.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching from last+1 upward, wrapping modulo NUM_REQ.
  - Next edge: grant <= onehot(winner), grant_id <= winner, last <= winner, burst_cnt <= 0, state <= GRANT.
  - If req == 0, stay in IDLE.
  - No write ever occurs in IDLE.
- GRANT:
  - Combinational accept = req[grant_id] & ~fifo_full.
  - fifo_wr = accept.
  - ack = grant when accept is high, else 0.
  - fifo_data = req_data lane grant_id, always driven (don't-care when fifo_wr=0).
  - On accept: burst_cnt increments.
  - Release to IDLE at the next edge if either:
    - accept occurs and burst_cnt+1 == MAX_BURST; or
    - req[grant_id]=0 (requester dropped; no write that cycle).
  - On release: grant <= 0, grant_id <= 0, burst_cnt <= 0.
  - fifo_full=1 with req held: no write, burst_cnt frozen, grant held indefinitely (no timeout).
- Latency:
  - Request seen in IDLE -> grant 1 cycle later -> first write in that same GRANT cycle if not full.
  - At least one IDLE cycle between consecutive grants, even to the same requester.
- Fairness:
  - The pointer advances only on grant.
  - A requester holding req continuously is served within NUM_REQ grants.
- Requests from non-granted requesters are ignored and never acked; they must hold req and data stable until acked.
- fifo_full is sampled combinationally and never registered, so a write can never be issued against a full FIFO.

Test Plan:
- Reset then req=4'b0001, 20 words, fifo_full=0 -> grant=0001 at cycle 2; ack on 16 consecutive cycles; release; 1 IDLE cycle; regrant to 0; remaining 4 words written; 20 fifo_wr total, data in order.
- req=4'b1111 held, each supplying 3 words -> grant order 0,1,2,3; each burst is 3 writes then release on req drop; fifo_data lanes match the grantee.
- Grant to 2, fifo_full=1 for 5 cycles after the 2nd word -> fifo_wr=0 and ack=0 for those 5 cycles; burst_cnt stays 2; grant held; writes resume when full drops.
- Assert rst during burst at burst_cnt=7 -> next cycle grant=0, busy=0, burst_cnt=0, no fifo_wr in the reset cycle; afterwards with req=4'b1010, requester 1 wins first.
- last=3 then req=4'b1001 -> requester 0 granted (wrap-around); next arbitration with both still requesting -> requester 3.
- NUM_REQ=2, MAX_BURST=1, both requesting continuously -> grants alternate 0,1,0,1 with one write per grant and one IDLE cycle between grants.
